dff_pair_scheduler: RTL and testbench

- Single-clock controller that owns one shared OR datapath and two result registers o1/o2.
- Two requesters compete for the datapath. Requester 1 computes a|b into o1; requester 2 computes b|c into o2.
- The block arbitrates round-robin, sequences each operation through a 3-state FSM, acknowledges completion and counts commits per channel.
- Replaces independently clocked result registers with one scheduled clock domain.

---
 rtl/dff_pair_scheduler_pkg.sv | 13 +
 rtl/dff_pair_scheduler_arb.sv | 22 ++
 rtl/dff_pair_scheduler.sv | 95 +++++++++
 tb/tb_dff_pair_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dff_pair_scheduler_pkg.sv
// Shared types for the paired-result scheduler: FSM state encoding and channel IDs.
package dff_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXEC   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam logic CH1 = 1'b0;
   localparam logic CH2 = 1'b1;

endpackage

// File: rtl/dff_pair_scheduler_arb.sv
// Two-way round-robin arbiter; on contention the channel not served last wins.
module rr_arbiter2
   import dff_sched_pkg::*;
(
   input  logic req1,
   input  logic req2,
   input  logic last_grant,
   output logic grant_valid,
   output logic sel
);

   always_comb begin
      grant_valid = req1 | req2;
      sel         = CH1;
      if (req1 && req2) begin
         sel = ~last_grant;
      end else if (req2) begin
         sel = CH2;
      end
   end

endmodule

// File: rtl/dff_pair_scheduler.sv
// Schedules two OR-result registers through one shared datapath with round-robin
// arbitration, a 3-state sequencer, commit acks and per-channel commit counters.
module dff_pair_scheduler
   import dff_sched_pkg::*;
#(
   parameter int unsigned DATA_W = 1,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req1,
   input  logic              req2,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   output logic              ack1,
   output logic              ack2,
   output logic [DATA_W-1:0] o1,
   output logic [DATA_W-1:0] o2,
   output logic              busy,
   output logic              last_grant,
   output logic [CNT_W-1:0]  cnt1,
   output logic [CNT_W-1:0]  cnt2
);

   state_t            state;
   logic              sel;
   logic [DATA_W-1:0] stage;
   logic              grant_valid;
   logic              arb_sel;

   rr_arbiter2 u_arb (
      .req1        (req1),
      .req2        (req2),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .sel         (arb_sel)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sel        <= CH1;
         stage      <= '0;
         o1         <= '0;
         o2         <= '0;
         ack1       <= 1'b0;
         ack2       <= 1'b0;
         busy       <= 1'b0;
         last_grant <= CH2;
         cnt1       <= '0;
         cnt2       <= '0;
      end else begin
         ack1 <= 1'b0;
         ack2 <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  sel   <= arb_sel;
                  stage <= (arb_sel == CH2) ? (b | c) : (a | b);
                  state <= EXEC;
                  busy  <= 1'b1;
               end
            end
            EXEC: begin
               if (sel == CH2) begin
                  o2 <= stage;
               end else begin
                  o1 <= stage;
               end
               state <= COMMIT;
            end
            COMMIT: begin
               // Ack, priority and count all land on the COMMIT exit edge, so the
               // next arbitration in IDLE already sees the updated last_grant.
               if (sel == CH2) begin
                  ack2 <= 1'b1;
                  cnt2 <= cnt2 + CNT_W'(1);
               end else begin
                  ack1 <= 1'b1;
                  cnt1 <= cnt1 + CNT_W'(1);
               end
               last_grant <= sel;
               state      <= IDLE;
               busy       <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dff_pair_scheduler.sv
// Directed bench for dff_pair_scheduler: expected commits are queued at stimulus time
// and checked against each ack by a monitor.
module tb_dff_pair_scheduler;

   logic       clk;
   logic       rst_n;
   logic       req1, req2;
   logic [0:0] a, b, c;
   logic       ack1, ack2;
   logic [0:0] o1, o2;
   logic       busy, last_grant;
   logic [7:0] cnt1, cnt2;

   typedef struct {
      logic       ch;
      logic       val;
      logic [7:0] cnt;
   } exp_t;

   exp_t       sb[$];
   int         compared   = 0;
   int         mismatched = 0;
   logic [7:0] m_cnt1     = 8'd0;
   logic [7:0] m_cnt2     = 8'd0;

   dff_pair_scheduler #(.DATA_W(1), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req1       (req1),
      .req2       (req2),
      .a          (a),
      .b          (b),
      .c          (c),
      .ack1       (ack1),
      .ack2       (ack2),
      .o1         (o1),
      .o2         (o2),
      .busy       (busy),
      .last_grant (last_grant),
      .cnt1       (cnt1),
      .cnt2       (cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_commit(input logic ch, input logic val);
      exp_t e;
      e.ch  = ch;
      e.val = val;
      if (ch) begin
         m_cnt2 = m_cnt2 + 8'd1;
         e.cnt  = m_cnt2;
      end else begin
         m_cnt1 = m_cnt1 + 8'd1;
         e.cnt  = m_cnt1;
      end
      sb.push_back(e);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ack"},  {ack1, ack2}, 2'b00);
      chk({tag, "_o"},    {o1, o2}, 2'b00);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_lg"},   last_grant, 1'b1);
      chk({tag, "_cnt"},  {cnt1, cnt2}, 16'h0000);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check_reset_vals("reset");
      m_cnt1 = 8'd0;
      m_cnt2 = 8'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b1;
      req1  = 1'b0;
      req2  = 1'b0;
      a     = '0;
      b     = '0;
      c     = '0;

      fork
         begin
            #200000;
            $display("FAIL timeout: observed no_finish expected finish");
            $fatal(1, "timeout");
         end
         forever begin
            @(negedge clk);
            if (rst_n && (ack1 || ack2)) begin
               if (sb.size() == 0) begin
                  chk("unexpected_ack", {ack1, ack2}, 2'b00);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  chk("ack_channel", {ack1, ack2}, e.ch ? 2'b01 : 2'b10);
                  chk("commit_value", e.ch ? o2 : o1, e.val);
                  chk("commit_count", e.ch ? cnt2 : cnt1, e.cnt);
               end
            end
         end
      join_none

      // 1: asynchronous reset mid-cycle
      #3;
      do_reset();

      // 2: single channel-1 request, a=1 b=0
      a = 1'b1; b = 1'b0; c = 1'b0; req1 = 1'b1;
      expect_commit(1'b0, 1'b1);
      @(negedge clk);                 // after edge 0
      req1 = 1'b0;
      chk("single_e0_busy", busy, 1'b1);
      chk("single_e0_o1", o1, 1'b0);
      @(negedge clk);                 // after edge 1
      chk("single_e1_o1", o1, 1'b1);
      chk("single_e1_busy", busy, 1'b1);
      chk("single_e1_ack", ack1, 1'b0);
      @(negedge clk);                 // after edge 2
      chk("single_e2_ack1", ack1, 1'b1);
      chk("single_e2_busy", busy, 1'b0);
      chk("single_e2_lg", last_grant, 1'b0);
      @(negedge clk);
      chk("single_e3_ack1", ack1, 1'b0);
      chk("single_o2_held", o2, 1'b0);

      // 3: contention from reset priority, alternating 1,2,1,2
      do_reset();
      a = 1'b0; b = 1'b1; c = 1'b0;
      req1 = 1'b1; req2 = 1'b1;
      expect_commit(1'b0, 1'b1);
      expect_commit(1'b1, 1'b1);
      expect_commit(1'b0, 1'b1);
      expect_commit(1'b1, 1'b1);
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);              // after edge k
         chk("contend_ack1", ack1, (k == 2 || k == 8) ? 1'b1 : 1'b0);
         chk("contend_ack2", ack2, (k == 5 || k == 11) ? 1'b1 : 1'b0);
         if (k == 11) begin
            req1 = 1'b0;
            req2 = 1'b0;
         end
      end
      chk("contend_o", {o1, o2}, 2'b11);
      chk("contend_cnt", {cnt1, cnt2}, {8'd2, 8'd2});

      // 4: operand change after grant does not disturb the in-flight op
      b = 1'b0; c = 1'b1; req2 = 1'b1;
      expect_commit(1'b1, 1'b1);
      @(negedge clk);
      req2 = 1'b0; c = 1'b0;
      repeat (3) @(negedge clk);
      chk("stable_o2", o2, 1'b1);
      chk("stable_o1_held", o1, 1'b1);

      // 5: one-cycle request still completes, with no second grant
      b = 1'b0; c = 1'b0; req2 = 1'b1;
      expect_commit(1'b1, 1'b0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 0) req2 = 1'b0;
         chk("drop_ack2", ack2, (k == 2) ? 1'b1 : 1'b0);
         chk("drop_busy", busy, (k < 2) ? 1'b1 : 1'b0);
      end
      chk("drop_o2", o2, 1'b0);
      chk("drop_cnt2", cnt2, 8'd4);

      // 6a: reset during EXEC loses the operation
      a = 1'b1; req1 = 1'b1;
      @(negedge clk);
      req1 = 1'b0;
      chk("abort_busy_before", busy, 1'b1);
      do_reset();
      repeat (3) @(negedge clk);
      chk("abort_o1", o1, 1'b0);
      chk("abort_cnt1", cnt1, 8'd0);

      // 6b: 256 channel-1 commits wrap the counter
      a = 1'b1; b = 1'b0;
      for (int i = 0; i < 256; i++) begin
         req1 = 1'b1;
         expect_commit(1'b0, 1'b1);
         @(negedge clk);
         req1 = 1'b0;
         repeat (2) @(negedge clk);
      end
      repeat (2) @(negedge clk);
      chk("wrap_cnt1", cnt1, 8'd0);
      chk("wrap_cnt2", cnt2, 8'd0);
      chk("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
